led_seq_arbiter: RTL and testbench
==================================

LED_SEQ_ARBITER -- requirements
Module: led_seq_arbiter

Interface
REQ-001 SHALL have parameter STEP_DIV, default 12_500_000; clocks per pattern step, min 2 (0.25 s at 50 MHz).
REQ-002 SHALL have port sys_clk  in  1  single clock for all logic.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port ps_valid  in  1  PS (EMIO) command request.
REQ-005 SHALL have port ps_mode  in  2  PS mode: 00 OFF, 01 STATIC, 10 BLINK, 11 SHIFT.
REQ-006 SHALL have port ps_pattern  in  4  PS LED pattern.
REQ-007 SHALL have port ps_len  in  4  PS step count; 0 means run until preempted.
REQ-008 SHALL have port ps_ready  out  1  PS command accepted when ps_valid and ps_ready.
REQ-009 SHALL have ports pl_valid, pl_mode, pl_pattern, pl_len, pl_ready: the same widths and meanings for the PL requester.
REQ-010 SHALL have port led  out  4  board LEDs, registered.
REQ-011 SHALL have port busy  out  1  pattern running.
REQ-012 SHALL have port owner  out  1  0 = PS, 1 = PL; owner of the current or last pattern.

Function
REQ-013 SHALL use FSM states IDLE and RUN; IDLE->RUN on any accept; RUN->IDLE when a finite count expires.
REQ-014 SHALL drive ps_ready = IDLE, or RUN with owner=PL, or RUN with len=0.
REQ-015 SHALL drive pl_ready = !ps_valid AND (IDLE, or RUN with owner=PL and len=0); combinational, no registers.
REQ-016 SHALL give PS fixed priority when both are valid in one cycle.
REQ-017 SHALL latch mode, pattern and len on accept, set owner, clear the step divider, and enter RUN the next cycle.
REQ-018 SHALL update led the cycle after accept: OFF->0000, STATIC/BLINK/SHIFT->pattern.
REQ-019 SHALL pulse step_tick for one cycle when div_cnt = STEP_DIV-1; div_cnt wraps to 0.
REQ-020 SHALL, on step_tick in RUN: STATIC/OFF hold led; BLINK toggle led between pattern and 0000; SHIFT rotate led left by 1 (bit3->bit0).
REQ-021 SHALL, for finite len, decrement steps_left on each step_tick; on the tick where steps_left = 1, go to IDLE with led holding its post-tick value.
REQ-022 SHALL treat an accept in RUN (preemption) exactly as REQ-017, discarding the old pattern with no extra cycle.
REQ-023 SHALL give an accept priority over a same-cycle step_tick; the tick is ignored.
REQ-024 SHALL drive busy = 1 exactly while in RUN.
REQ-025 SHALL hold a PS request when it arrives on the completing cycle of a PS finite pattern (ready=0) and accept it the next cycle in IDLE.

Reset
REQ-026 SHALL, on rst_n=0 at a sys_clk edge: state IDLE, led 0000, busy 0, owner 0, div_cnt 0, steps_left 0, latched command cleared.
REQ-027 SHALL abort a running pattern on reset mid-operation, with no request accepted during reset.

Structure
REQ-028 SHALL place the mode encoding, FSM state encoding and owner encoding in shared package led_ctrl_pkg.
REQ-029 SHALL implement the divider as sub-module led_step_timer (inputs: clear and enable; output: step_tick; parameter STEP_DIV).
REQ-030 SHALL take the parameter from the instantiating top, so the block sits beside the existing LED logic under top with PS requests arriving over EMIO.

Verification (STEP_DIV=4)
REQ-031 SHALL check: after reset, PS SHIFT pattern=0001 len=3 -> led 0001, 0010, 0100, 1000 at 4-cycle steps; busy drops with the last step; led holds 1000.
REQ-032 SHALL check: ps_valid and pl_valid in the same IDLE cycle -> ps_ready=1, pl_ready=0, owner=0.
REQ-033 SHALL check: PL BLINK 1010 len=0 running, then PS STATIC 0110 -> accepted at once; led=0110 the next cycle; owner=0.
REQ-034 SHALL check: PS STATIC len=2 running, then pl_valid -> pl_ready stays 0 until IDLE, then accepts.
REQ-035 SHALL check: rst_n=0 for one cycle mid-SHIFT -> next cycle led=0000, busy=0, and the divider restarts from 0.
REQ-036 SHALL check: accept coincident with step_tick -> the new pattern appears unmodified and the first new step comes 4 cycles later.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED sequence arbiter: command modes, FSM states,
// requester ownership, the latched command record and the per-step LED rules.
// No ports; imported by led_seq_arbiter and its testbench.
package led_ctrl_pkg;

  localparam int unsigned LED_W = 4;
  localparam int unsigned LEN_W = 4;

  // Mode field as it arrives on ps_mode / pl_mode.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_SHIFT  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Value presented on the owner output.
  typedef enum logic {
    OWNER_PS = 1'b0,
    OWNER_PL = 1'b1
  } owner_e;

  // Command captured on accept. len == 0 means run until preempted.
  typedef struct packed {
    mode_e              mode;
    logic [LED_W-1:0]   pattern;
    logic [LEN_W-1:0]   len;
  } cmd_t;

  localparam cmd_t CMD_CLEAR = '{mode: MODE_OFF, pattern: '0, len: '0};

  // LED value loaded in the cycle after a command is accepted.
  function automatic logic [LED_W-1:0] led_on_accept(input cmd_t c);
    return (c.mode == MODE_OFF) ? '0 : c.pattern;
  endfunction

  // LED value after one pattern step of the running command.
  function automatic logic [LED_W-1:0] led_on_step(input cmd_t c,
                                                   input logic [LED_W-1:0] cur);
    logic [LED_W-1:0] nxt;
    nxt = cur;
    case (c.mode)
      // Toggle between the pattern and dark; a dark LED means "show pattern".
      MODE_BLINK: nxt = (cur == '0) ? c.pattern : '0;
      // Rotate left, bit 3 wraps into bit 0.
      MODE_SHIFT: nxt = {cur[LED_W-2:0], cur[LED_W-1]};
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step divider: counts sys_clk cycles while enabled and pulses step_tick for
// one cycle every STEP_DIV cycles (on the cycle the count equals STEP_DIV-1).
// Ports: sys_clk, rst_n (sync, active-low), clear (restart at 0), enable, step_tick.
module led_step_timer #(
  parameter int unsigned STEP_DIV = 12_500_000  // must be >= 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic step_tick
);

  localparam int unsigned CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = '0;
    end else if (enable) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // The tick is raw; the caller decides whether a same-cycle clear wins.
  assign step_tick = enable && (div_cnt_q == LAST);

endmodule

// File: rtl/led_seq_arbiter.sv
// Arbitrates LED pattern commands from the PS (EMIO) and PL requesters and
// plays the accepted pattern (OFF/STATIC/BLINK/SHIFT) on the board LEDs.
// Ports: sys_clk, rst_n (sync, active-low); ps_/pl_ valid/mode/pattern/len/ready
// request channels; led (registered), busy (pattern running), owner (0 PS, 1 PL).
module led_seq_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int unsigned STEP_DIV = 12_500_000
) (
  input  logic       sys_clk,
  input  logic       rst_n,

  input  logic       ps_valid,
  input  logic [1:0] ps_mode,
  input  logic [3:0] ps_pattern,
  input  logic [3:0] ps_len,
  output logic       ps_ready,

  input  logic       pl_valid,
  input  logic [1:0] pl_mode,
  input  logic [3:0] pl_pattern,
  input  logic [3:0] pl_len,
  output logic       pl_ready,

  output logic [3:0] led,
  output logic       busy,
  output logic       owner
);

  state_e            state_q, state_d;
  cmd_t              cmd_q,   cmd_d;
  owner_e            owner_q, owner_d;
  logic [LED_W-1:0]  led_q,   led_d;
  logic [LEN_W-1:0]  steps_q, steps_d;

  logic   ps_acc;
  logic   pl_acc;
  logic   timer_clear;
  logic   step_tick;
  cmd_t   new_cmd;
  owner_e new_owner;

  // ---------------------------------------------------------------------------
  // Ready / accept
  // ---------------------------------------------------------------------------
  // PS may always preempt PL, and may replace its own open-ended pattern, but
  // never cuts short its own finite pattern. PL only gets in when the PS is not
  // asking and the block is idle or running an open-ended PL pattern. Both
  // readies are held low while reset is asserted so nothing is accepted then.
  always_comb begin
    logic is_idle;
    logic open_ended;
    is_idle    = (state_q == ST_IDLE);
    open_ended = (cmd_q.len == '0);

    ps_ready = rst_n && (is_idle || (owner_q == OWNER_PL) || open_ended);
    pl_ready = rst_n && !ps_valid &&
               (is_idle || ((owner_q == OWNER_PL) && open_ended));

    // pl_ready already excludes ps_valid, so the two never fire together.
    ps_acc = ps_valid && ps_ready;
    pl_acc = pl_valid && pl_ready;

    new_cmd   = CMD_CLEAR;
    new_owner = OWNER_PS;
    if (ps_acc) begin
      new_cmd.mode    = mode_e'(ps_mode);
      new_cmd.pattern = ps_pattern;
      new_cmd.len     = ps_len;
      new_owner       = OWNER_PS;
    end else if (pl_acc) begin
      new_cmd.mode    = mode_e'(pl_mode);
      new_cmd.pattern = pl_pattern;
      new_cmd.len     = pl_len;
      new_owner       = OWNER_PL;
    end
  end

  // ---------------------------------------------------------------------------
  // Step divider
  // ---------------------------------------------------------------------------
  led_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .clear     (timer_clear),
    .enable    (state_q == ST_RUN),
    .step_tick (step_tick)
  );

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    owner_d     = owner_q;
    led_d       = led_q;
    steps_d     = steps_q;
    timer_clear = 1'b0;

    if (ps_acc || pl_acc) begin
      // A new command (also a preemption) restarts everything; a step tick
      // landing in the same cycle belongs to the discarded pattern and is dropped.
      cmd_d       = new_cmd;
      owner_d     = new_owner;
      led_d       = led_on_accept(new_cmd);
      steps_d     = new_cmd.len;
      state_d     = ST_RUN;
      timer_clear = 1'b1;
    end else if ((state_q == ST_RUN) && step_tick) begin
      led_d = led_on_step(cmd_q, led_q);
      if (cmd_q.len != '0) begin
        steps_d = steps_q - LEN_W'(1);
        // Last step: the LEDs keep the value produced by this tick.
        if (steps_q == LEN_W'(1)) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_CLEAR;
      owner_q <= OWNER_PS;
      led_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
      led_q   <= led_d;
      steps_q <= steps_d;
    end
  end

  assign led   = led_q;
  assign busy  = (state_q == ST_RUN);
  assign owner = owner_q;

endmodule

// File: tb/tb_led_seq_arbiter.sv
// Directed self-checking bench for led_seq_arbiter with STEP_DIV = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// Each scenario task carries its own hand-computed expectations.
module tb_led_seq_arbiter;

  localparam logic [1:0] M_OFF    = 2'b00;
  localparam logic [1:0] M_STATIC = 2'b01;
  localparam logic [1:0] M_BLINK  = 2'b10;
  localparam logic [1:0] M_SHIFT  = 2'b11;

  logic       sys_clk;
  logic       rst_n;
  logic       ps_valid;
  logic [1:0] ps_mode;
  logic [3:0] ps_pattern;
  logic [3:0] ps_len;
  logic       ps_ready;
  logic       pl_valid;
  logic [1:0] pl_mode;
  logic [3:0] pl_pattern;
  logic [3:0] pl_len;
  logic       pl_ready;
  logic [3:0] led;
  logic       busy;
  logic       owner;

  int n_cmp = 0;
  int n_err = 0;

  led_seq_arbiter #(.STEP_DIV(4)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .ps_valid   (ps_valid),
    .ps_mode    (ps_mode),
    .ps_pattern (ps_pattern),
    .ps_len     (ps_len),
    .ps_ready   (ps_ready),
    .pl_valid   (pl_valid),
    .pl_mode    (pl_mode),
    .pl_pattern (pl_pattern),
    .pl_len     (pl_len),
    .pl_ready   (pl_ready),
    .led        (led),
    .busy       (busy),
    .owner      (owner)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_ps(input logic v, input logic [1:0] m, input logic [3:0] p,
                        input logic [3:0] l);
    ps_valid = v; ps_mode = m; ps_pattern = p; ps_len = l;
  endtask

  task automatic set_pl(input logic v, input logic [1:0] m, input logic [3:0] p,
                        input logic [3:0] l);
    pl_valid = v; pl_mode = m; pl_pattern = p; pl_len = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    set_pl(1'b0, M_OFF, 4'b0000, 4'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (led !== 4'b0000) begin n_err++; $display("FAIL reset_led got=%b exp=0000", led); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL reset_owner got=%b exp=0", owner); end
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL reset_ps_ready got=%b exp=1", ps_ready); end
    n_cmp++; if (pl_ready !== 1'b1) begin n_err++; $display("FAIL reset_pl_ready got=%b exp=1", pl_ready); end
  endtask

  task automatic test_shift_finite();
    logic [3:0] exp_led [4];
    logic       exp_busy;
    exp_led = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    set_ps(1'b1, M_SHIFT, 4'b0001, 4'd3);
    #1;
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL shift_ps_ready got=%b exp=1", ps_ready); end
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b0001) begin n_err++; $display("FAIL shift_first_led got=%b exp=0001", led); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL shift_busy got=%b exp=1", busy); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL shift_owner got=%b exp=0", owner); end
    for (int s = 1; s <= 3; s++) begin
      repeat (3) begin
        step();
        n_cmp++; if (led !== exp_led[s-1]) begin n_err++; $display("FAIL shift_hold%0d got=%b exp=%b", s, led, exp_led[s-1]); end
      end
      step();
      exp_busy = (s < 3);
      n_cmp++; if (led !== exp_led[s]) begin n_err++; $display("FAIL shift_step%0d got=%b exp=%b", s, led, exp_led[s]); end
      n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL shift_busy%0d got=%b exp=%b", s, busy, exp_busy); end
    end
    repeat (4) step();
    n_cmp++; if (led !== 4'b1000) begin n_err++; $display("FAIL shift_final_hold got=%b exp=1000", led); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL shift_final_busy got=%b exp=0", busy); end
  endtask

  task automatic test_simultaneous();
    set_ps(1'b1, M_STATIC, 4'b1111, 4'd1);
    set_pl(1'b1, M_OFF, 4'b0101, 4'd0);
    #1;
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL simul_ps_ready got=%b exp=1", ps_ready); end
    n_cmp++; if (pl_ready !== 1'b0) begin n_err++; $display("FAIL simul_pl_ready got=%b exp=0", pl_ready); end
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    set_pl(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL simul_owner got=%b exp=0", owner); end
    n_cmp++; if (led !== 4'b1111) begin n_err++; $display("FAIL simul_led got=%b exp=1111", led); end
    repeat (3) step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL simul_busy_mid got=%b exp=1", busy); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_busy_end got=%b exp=0", busy); end
    n_cmp++; if (led !== 4'b1111) begin n_err++; $display("FAIL simul_led_end got=%b exp=1111", led); end
  endtask

  task automatic test_preempt();
    set_pl(1'b1, M_BLINK, 4'b1010, 4'd0);
    #1;
    n_cmp++; if (pl_ready !== 1'b1) begin n_err++; $display("FAIL preempt_pl_ready got=%b exp=1", pl_ready); end
    step();
    set_pl(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b1010) begin n_err++; $display("FAIL preempt_pl_led got=%b exp=1010", led); end
    n_cmp++; if (owner !== 1'b1) begin n_err++; $display("FAIL preempt_pl_owner got=%b exp=1", owner); end
    repeat (4) step();
    n_cmp++; if (led !== 4'b0000) begin n_err++; $display("FAIL preempt_blink_off got=%b exp=0000", led); end
    set_ps(1'b1, M_STATIC, 4'b0110, 4'd0);
    #1;
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL preempt_ps_ready got=%b exp=1", ps_ready); end
    n_cmp++; if (pl_ready !== 1'b0) begin n_err++; $display("FAIL preempt_pl_blocked got=%b exp=0", pl_ready); end
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b0110) begin n_err++; $display("FAIL preempt_ps_led got=%b exp=0110", led); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL preempt_ps_owner got=%b exp=0", owner); end
    repeat (4) step();
    n_cmp++; if (led !== 4'b0110) begin n_err++; $display("FAIL preempt_static_hold got=%b exp=0110", led); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL preempt_busy got=%b exp=1", busy); end
  endtask

  task automatic test_pl_blocked();
    set_ps(1'b1, M_STATIC, 4'b0011, 4'd2);
    #1;
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL blocked_ps_ready got=%b exp=1", ps_ready); end
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    set_pl(1'b1, M_STATIC, 4'b1100, 4'd1);
    #1;
    n_cmp++; if (pl_ready !== 1'b0) begin n_err++; $display("FAIL blocked_pl_ready0 got=%b exp=0", pl_ready); end
    for (int i = 1; i <= 7; i++) begin
      step();
      n_cmp++; if (pl_ready !== 1'b0) begin n_err++; $display("FAIL blocked_pl_ready%0d got=%b exp=0", i, pl_ready); end
    end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL blocked_done_busy got=%b exp=0", busy); end
    n_cmp++; if (pl_ready !== 1'b1) begin n_err++; $display("FAIL blocked_idle_pl_ready got=%b exp=1", pl_ready); end
    n_cmp++; if (led !== 4'b0011) begin n_err++; $display("FAIL blocked_done_led got=%b exp=0011", led); end
    step();
    set_pl(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b1100) begin n_err++; $display("FAIL blocked_pl_led got=%b exp=1100", led); end
    n_cmp++; if (owner !== 1'b1) begin n_err++; $display("FAIL blocked_pl_owner got=%b exp=1", owner); end
  endtask

  task automatic test_reset_mid();
    set_ps(1'b1, M_SHIFT, 4'b0001, 4'd0);
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b0001) begin n_err++; $display("FAIL rstmid_start_led got=%b exp=0001", led); end
    repeat (4) step();
    n_cmp++; if (led !== 4'b0010) begin n_err++; $display("FAIL rstmid_step_led got=%b exp=0010", led); end
    repeat (2) step();
    // Request held through reset must not be taken.
    rst_n = 1'b0;
    set_ps(1'b1, M_STATIC, 4'b1111, 4'd0);
    step();
    n_cmp++; if (led !== 4'b0000) begin n_err++; $display("FAIL rstmid_led got=%b exp=0000", led); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL rstmid_owner got=%b exp=0", owner); end
    rst_n = 1'b1;
    set_ps(1'b1, M_SHIFT, 4'b1000, 4'd0);
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b1000) begin n_err++; $display("FAIL rstmid_new_led got=%b exp=1000", led); end
    repeat (3) step();
    n_cmp++; if (led !== 4'b1000) begin n_err++; $display("FAIL rstmid_new_hold got=%b exp=1000", led); end
    step();
    n_cmp++; if (led !== 4'b0001) begin n_err++; $display("FAIL rstmid_new_step got=%b exp=0001", led); end
  endtask

  task automatic test_tick_collision();
    // Three more cycles put the running SHIFT on its tick cycle.
    repeat (3) step();
    set_ps(1'b1, M_BLINK, 4'b0101, 4'd0);
    #1;
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL collide_ps_ready got=%b exp=1", ps_ready); end
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b0101) begin n_err++; $display("FAIL collide_led got=%b exp=0101", led); end
    repeat (3) step();
    n_cmp++; if (led !== 4'b0101) begin n_err++; $display("FAIL collide_hold got=%b exp=0101", led); end
    step();
    n_cmp++; if (led !== 4'b0000) begin n_err++; $display("FAIL collide_first_step got=%b exp=0000", led); end
  endtask

  task automatic test_back_to_back();
    set_ps(1'b1, M_SHIFT, 4'b0011, 4'd1);
    #1;
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ps_ready got=%b exp=1", ps_ready); end
    step();
    set_ps(1'b1, M_STATIC, 4'b1001, 4'd0);
    #1;
    n_cmp++; if (ps_ready !== 1'b0) begin n_err++; $display("FAIL b2b_blocked got=%b exp=0", ps_ready); end
    n_cmp++; if (led !== 4'b0011) begin n_err++; $display("FAIL b2b_first_led got=%b exp=0011", led); end
    repeat (3) step();
    n_cmp++; if (ps_ready !== 1'b0) begin n_err++; $display("FAIL b2b_last_cycle_ready got=%b exp=0", ps_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_last_cycle_busy got=%b exp=1", busy); end
    step();
    n_cmp++; if (led !== 4'b0110) begin n_err++; $display("FAIL b2b_done_led got=%b exp=0110", led); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_busy got=%b exp=0", busy); end
    n_cmp++; if (ps_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_ready got=%b exp=1", ps_ready); end
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b1001) begin n_err++; $display("FAIL b2b_next_led got=%b exp=1001", led); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_next_busy got=%b exp=1", busy); end
  endtask

  task automatic test_off_mode();
    set_ps(1'b1, M_OFF, 4'b1111, 4'd0);
    step();
    set_ps(1'b0, M_OFF, 4'b0000, 4'd0);
    n_cmp++; if (led !== 4'b0000) begin n_err++; $display("FAIL off_led got=%b exp=0000", led); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL off_busy got=%b exp=1", busy); end
  endtask

  initial begin
    test_reset();
    test_shift_finite();
    test_simultaneous();
    test_preempt();
    test_pl_blocked();
    test_reset_mid();
    test_tick_collision();
    test_back_to_back();
    test_off_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
    $fatal(1);
  end

endmodule
